// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: operation encodings, FSM states,
// sub-word lane helpers and the default memory map.
package lsu_pkg;

  // Request operation encodings
  localparam logic [2:0] OpLb  = 3'd0;
  localparam logic [2:0] OpLbu = 3'd1;
  localparam logic [2:0] OpLh  = 3'd2;
  localparam logic [2:0] OpLhu = 3'd3;
  localparam logic [2:0] OpLw  = 3'd4;
  localparam logic [2:0] OpSb  = 3'd5;
  localparam logic [2:0] OpSh  = 3'd6;
  localparam logic [2:0] OpSw  = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StResp
  } lsu_state_e;

  // Default memory map
  localparam logic [31:0] DefaultBaseAddr = 32'h1001_0000;
  localparam int unsigned DefaultMemWords = 4096;

  // Lane widths
  localparam int unsigned ByteBits = 8;
  localparam int unsigned HalfBits = 16;

  // Bit position of little-endian byte lane 'off' within a word
  function automatic logic [4:0] lane_shift(input logic [1:0] off);
    return {off, 3'b000};
  endfunction

  function automatic logic is_load(input logic [2:0] op);
    return op <= OpLw;
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
    if (op == OpLh || op == OpLhu || op == OpSh) return lo[0];
    if (op == OpLw || op == OpSw) return lo != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational sub-word lane handling for the load/store unit.
//   op, offset   : operation code and byte offset within the word
//   word         : memory word (read data, or old word for a merge)
//   wdata        : right-justified store data
//   load_data    : lane-extracted, sign/zero-extended load result
//   store_word   : word to write back (merged for SB/SH, wdata for SW)
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [ByteBits-1:0] lane_byte;
  logic [HalfBits-1:0] lane_half;

  always_comb begin
    lane_byte = word[lane_shift(offset) +: ByteBits];
    // Halfword accesses are 2-aligned, so offset[1] picks the half
    lane_half = offset[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (op)
      OpLb:    load_data = {{(32 - ByteBits){lane_byte[ByteBits-1]}}, lane_byte};
      OpLbu:   load_data = {{(32 - ByteBits){1'b0}}, lane_byte};
      OpLh:    load_data = {{(32 - HalfBits){lane_half[HalfBits-1]}}, lane_half};
      OpLhu:   load_data = {{(32 - HalfBits){1'b0}}, lane_half};
      default: load_data = word;
    endcase

    store_word = wdata;
    case (op)
      OpSb: begin
        store_word = word;
        store_word[lane_shift(offset) +: ByteBits] = wdata[ByteBits-1:0];
      end
      OpSh: begin
        store_word = offset[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory interface.
// Accepts one request at a time (req_*), runs word-wide memory cycles
// (mem_*), and returns a response (resp_*). Sub-word stores use a
// read-then-write cycle pair; misaligned or out-of-range requests are
// answered with resp_err and never touch memory.
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : request handshake; req_op/addr/wdata captured on accept
//   resp_valid/ready  : response handshake; resp_rdata, resp_err
//   mem_read/write    : one-cycle strobes decoded from state
//   mem_address       : word-aligned address, held between strobes
//   mem_write_data    : write word, held between strobes
//   mem_read_data     : combinational read data from memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DefaultBaseAddr,
  parameter int unsigned MEM_WORDS = DefaultMemWords
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  // One past the last valid byte address; 33 bits so the top of the map cannot wrap
  localparam logic [32:0] AddrEnd = {1'b0, BASE_ADDR} + (33'(MEM_WORDS) << 2);

  lsu_state_e  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mwdata_q, mwdata_d;

  logic        accept;
  logic        out_of_range;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] store_word;

  lsu_lane_align u_lane_align (
    .op         (op_q),
    .offset     (off_q),
    .word       (mem_read_data),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  assign req_ready    = rst_n && (state_q == StIdle);
  assign accept       = req_valid && req_ready;
  assign out_of_range = (req_addr < BASE_ADDR) || ({1'b0, req_addr} >= AddrEnd);
  assign req_err      = misaligned(req_op, req_addr[1:0]) || out_of_range;

  // Strobes come from state alone so an asynchronous reset drops them at once
  assign mem_read       = (state_q == StRead);
  assign mem_write      = (state_q == StWrite);
  assign mem_address    = maddr_q;
  assign mem_write_data = mwdata_q;
  assign resp_valid     = (state_q == StResp);
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = req_op;
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = req_err;
          if (req_err) begin
            state_d = StResp;
          end else begin
            maddr_d = {req_addr[31:2], 2'b00};
            if (req_op == OpSw) begin
              mwdata_d = req_wdata;
              state_d  = StWrite;
            end else begin
              state_d = StRead;
            end
          end
        end
      end
      StRead: begin
        if (is_load(op_q)) begin
          rdata_d = load_data;
          state_d = StResp;
        end else begin
          mwdata_d = store_word;
          state_d  = StWrite;
        end
      end
      StWrite: state_d = StResp;
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      off_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

endmodule
